// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle control unit: accepts one instruction per handshake, decodes it into the
// datapath control bundle and sequences DECODE/EXEC/MEM/WB with sticky halt/illegal/timeout.
module ctrl_fsm_mc #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  output logic        inst_ready_o,
  input  logic        mem_done_i,
  output logic [2:0]  i_type_o,
  output logic        alu_a_src_o,
  output logic [1:0]  alu_b_src_o,
  output logic [3:0]  alu_ctr_o,
  output logic        alu_word_o,
  output logic        mem_to_reg_o,
  output logic [2:0]  mem_op_o,
  output logic [2:0]  branch_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        reg_we_o,
  output logic        pc_we_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic        timeout_o
);

  localparam bit              RV64    = (XLEN == 64);
  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] IT_I = 3'd0, IT_S = 3'd1, IT_B = 3'd2, IT_U = 3'd3, IT_J = 3'd4, IT_R = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3, ALU_XOR = 4'd4,
                         ALU_OR  = 4'd5, ALU_AND = 4'd6, ALU_SLL = 4'd7, ALU_SRL  = 4'd8, ALU_SRA = 4'd9;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  // Only two func3 values are unused by B-type; JALR shares BGEU's code and is told apart by alu_ctr.
  localparam logic [2:0] BR_NONE = 3'b010, BR_PC = 3'b011, BR_REG = 3'b111;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67,
                         OPC_BR  = 7'h63, OPC_LOAD  = 7'h03, OPC_STORE = 7'h23, OPC_OPIMM = 7'h13,
                         OPC_OP  = 7'h33, OPC_OPIMM32 = 7'h1B, OPC_OP32 = 7'h3B;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR} state_e;

  typedef struct packed {
    logic [2:0] itype;
    logic       a_src;
    logic [1:0] b_src;
    logic [3:0] alu;
    logic       word;
    logic       m2r;
    logic [2:0] mop;
    logic [2:0] br;
    logic       ld;
    logic       st;
    logic       wr;
  } ctrl_t;

  state_e          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic            dec_legal, dec_ebreak, wr_rd;
  logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, reg_we_q, reg_we_d, pc_we_q, pc_we_d;
  logic            halt_q, halt_d, illegal_q, illegal_d, timeout_q, timeout_d;

  logic [6:0] opc;
  logic [2:0] f3;
  assign opc = inst_q[6:0];
  assign f3  = inst_q[14:12];

  function automatic logic [3:0] alu_of(input logic [2:0] fn3, input logic b5, input logic r);
    case (fn3)
      3'b000:  return (r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction decode from the latched word
  always_comb begin
    dec        = '0;
    dec.itype  = IT_I;
    dec.alu    = ALU_ADD;
    dec.br     = BR_NONE;
    dec_legal  = 1'b0;
    wr_rd      = 1'b0;
    dec_ebreak = (inst_q == EBREAK);
    case (opc)
      OPC_LUI:   begin dec.itype = IT_U; dec.b_src = B_IMM; wr_rd = 1'b1; dec_legal = 1'b1; end
      OPC_AUIPC: begin dec.itype = IT_U; dec.a_src = 1'b1; dec.b_src = B_IMM; wr_rd = 1'b1; dec_legal = 1'b1; end
      OPC_JAL: begin
        dec.itype = IT_J; dec.a_src = 1'b1; dec.b_src = B_FOUR; dec.br = BR_PC;
        wr_rd = 1'b1; dec_legal = 1'b1;
      end
      OPC_JALR: begin dec.b_src = B_IMM; dec.br = BR_REG; wr_rd = 1'b1; dec_legal = 1'b1; end
      OPC_BR:   begin dec.itype = IT_B; dec.alu = ALU_SLT; dec.br = f3; dec_legal = 1'b1; end
      OPC_LOAD: begin
        dec.b_src = B_IMM; dec.m2r = 1'b1; dec.mop = f3; dec.ld = 1'b1; wr_rd = 1'b1;
        dec_legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                    (RV64 && (f3 inside {3'b011, 3'b110}));
      end
      OPC_STORE: begin
        dec.itype = IT_S; dec.b_src = B_IMM; dec.mop = f3; dec.st = 1'b1;
        dec_legal = (f3 <= 3'b010) || (RV64 && (f3 == 3'b011));
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        dec.b_src = B_IMM; dec.alu = alu_of(f3, inst_q[30], 1'b0);
        dec.word  = RV64 && (opc == OPC_OPIMM32);
        wr_rd = 1'b1; dec_legal = RV64 || (opc == OPC_OPIMM);
      end
      OPC_OP, OPC_OP32: begin
        dec.itype = IT_R; dec.alu = alu_of(f3, inst_q[30], 1'b1);
        dec.word  = RV64 && (opc == OPC_OP32);
        wr_rd = 1'b1; dec_legal = RV64 || (opc == OPC_OP);
      end
      default: dec_legal = 1'b0;
    endcase
    dec.wr = wr_rd && (inst_q[11:7] != 5'd0);
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      pc_we_q   <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      reg_we_q  <= reg_we_d;
      pc_we_q   <= pc_we_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (inst_valid_i) begin
        inst_d  = inst_i;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ebreak)     state_d = S_HALT;
        else if (!dec_legal) state_d = S_ERR;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d   = '0;
        state_d = (ctrl_q.ld || ctrl_q.st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_done_i)                      state_d = S_WB;
        else if (TO_EN && (cnt_q == TO_LAST)) state_d = S_ERR;
        else                                 cnt_d = cnt_q + TO_W'(1);
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = state_q;
    endcase
  end

  // Output next values, registered alongside the state
  always_comb begin
    ctrl_d    = ctrl_q;
    if (state_q == S_DECODE) ctrl_d = dec;
    mem_rd_d  = (state_d == S_MEM) && ctrl_q.ld;
    mem_wr_d  = (state_d == S_MEM) && ctrl_q.st;
    pc_we_d   = (state_d == S_WB);
    reg_we_d  = (state_d == S_WB) && ctrl_q.wr;
    halt_d    = halt_q    || (state_d == S_HALT);
    illegal_d = illegal_q || ((state_q == S_DECODE) && (state_d == S_ERR));
    timeout_d = timeout_q || ((state_q == S_MEM) && (state_d == S_ERR));
  end

  assign inst_ready_o = (state_q == S_IDLE) && !rst_i;
  assign i_type_o     = ctrl_q.itype;
  assign alu_a_src_o  = ctrl_q.a_src;
  assign alu_b_src_o  = ctrl_q.b_src;
  assign alu_ctr_o    = ctrl_q.alu;
  assign alu_word_o   = ctrl_q.word;
  assign mem_to_reg_o = ctrl_q.m2r;
  assign mem_op_o     = ctrl_q.mop;
  assign branch_o     = ctrl_q.br;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wr_o     = mem_wr_q;
  assign reg_we_o     = reg_we_q;
  assign pc_we_o      = pc_we_q;
  assign halt_o       = halt_q;
  assign illegal_o    = illegal_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Bench for ctrl_fsm_mc: an RV32 and an RV64 instance share stimulus; each is compared
// cycle by cycle against a per-instruction timeline derived from the decode rules.
module tb_ctrl_fsm_mc;
  localparam int TO = 4;
  localparam int K_OK = 0, K_HALT = 1, K_ILL = 2;
  localparam logic [2:0] IT_I = 3'd0, IT_S = 3'd1, IT_B = 3'd2, IT_U = 3'd3, IT_J = 3'd4, IT_R = 3'd5;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3, A_XOR = 4'd4,
                         A_OR  = 4'd5, A_AND = 4'd6, A_SLL = 4'd7, A_SRL  = 4'd8, A_SRA = 4'd9;
  localparam logic [2:0] BR_NONE = 3'b010, BR_PC = 3'b011, BR_REG = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, inst_valid = 1'b0, mem_done = 1'b0;
  logic [31:0] inst = '0;
  logic [1:0]  inst_ready, alu_a_src, alu_word, mem_to_reg, mem_rd, mem_wr, reg_we, pc_we;
  logic [1:0]  halt, illegal, timeout;
  logic [1:0][2:0] i_type, mem_op, branch;
  logic [1:0][1:0] alu_b_src;
  logic [1:0][3:0] alu_ctr;

  ctrl_fsm_mc #(.XLEN(32), .MEM_TIMEOUT(TO), .TO_W(3)) u_rv32 (
    .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .inst_i(inst), .inst_ready_o(inst_ready[0]),
    .mem_done_i(mem_done), .i_type_o(i_type[0]), .alu_a_src_o(alu_a_src[0]), .alu_b_src_o(alu_b_src[0]),
    .alu_ctr_o(alu_ctr[0]), .alu_word_o(alu_word[0]), .mem_to_reg_o(mem_to_reg[0]), .mem_op_o(mem_op[0]),
    .branch_o(branch[0]), .mem_rd_o(mem_rd[0]), .mem_wr_o(mem_wr[0]), .reg_we_o(reg_we[0]),
    .pc_we_o(pc_we[0]), .halt_o(halt[0]), .illegal_o(illegal[0]), .timeout_o(timeout[0]));

  ctrl_fsm_mc #(.XLEN(64), .MEM_TIMEOUT(TO), .TO_W(3)) u_rv64 (
    .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .inst_i(inst), .inst_ready_o(inst_ready[1]),
    .mem_done_i(mem_done), .i_type_o(i_type[1]), .alu_a_src_o(alu_a_src[1]), .alu_b_src_o(alu_b_src[1]),
    .alu_ctr_o(alu_ctr[1]), .alu_word_o(alu_word[1]), .mem_to_reg_o(mem_to_reg[1]), .mem_op_o(mem_op[1]),
    .branch_o(branch[1]), .mem_rd_o(mem_rd[1]), .mem_wr_o(mem_wr[1]), .reg_we_o(reg_we[1]),
    .pc_we_o(pc_we[1]), .halt_o(halt[1]), .illegal_o(illegal[1]), .timeout_o(timeout[1]));

  typedef struct {
    int         kind;
    bit         ld, st, wr, a, word, m2r;
    logic [2:0] ity, mop, br;
    logic [1:0] b;
    logic [3:0] alu;
  } exp_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h @%0t", tag, got, want, $time);
  endtask

  // Expected decode of one instruction for a given datapath width
  function automatic exp_t model(input logic [31:0] ins, input bit rv64);
    exp_t       e;
    logic [3:0] tab [8];
    logic [6:0] op;
    logic [2:0] f3;
    bit         w, r, wrd;
    tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    op  = ins[6:0];
    f3  = ins[14:12];
    e   = '{kind: K_ILL, default: 0};
    e.ity = IT_I; e.br = BR_NONE; e.alu = A_ADD; wrd = 0;
    if (ins == 32'h0010_0073) begin e.kind = K_HALT; return e; end
    case (op)
      7'h37: begin e.kind = K_OK; e.ity = IT_U; e.b = 2'b01; wrd = 1; end
      7'h17: begin e.kind = K_OK; e.ity = IT_U; e.a = 1; e.b = 2'b01; wrd = 1; end
      7'h6F: begin e.kind = K_OK; e.ity = IT_J; e.a = 1; e.b = 2'b10; e.br = BR_PC; wrd = 1; end
      7'h67: begin e.kind = K_OK; e.b = 2'b01; e.br = BR_REG; wrd = 1; end
      7'h63: begin e.kind = K_OK; e.ity = IT_B; e.alu = A_SLT; e.br = f3; end
      7'h03: if ((f3 inside {0, 1, 2, 4, 5}) || (rv64 && (f3 inside {3, 6}))) begin
        e.kind = K_OK; e.ld = 1; e.m2r = 1; e.mop = f3; e.b = 2'b01; wrd = 1;
      end
      7'h23: if (f3 < 3 || (rv64 && f3 == 3)) begin
        e.kind = K_OK; e.st = 1; e.ity = IT_S; e.mop = f3; e.b = 2'b01;
      end
      7'h13, 7'h1B, 7'h33, 7'h3B: begin
        w = op[3]; r = op[5];
        if (!w || rv64) begin
          e.kind = K_OK; e.ity = r ? IT_R : IT_I; e.b = r ? 2'b00 : 2'b01;
          e.alu = tab[f3];
          if (ins[30] && f3 == 3'd5) e.alu = A_SRA;
          if (ins[30] && r && f3 == 3'd0) e.alu = A_SUB;
          e.word = w; wrd = 1;
        end
      end
      default: ;
    endcase
    e.wr = wrd && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic int wb_of(input exp_t e, input int k);
    return (e.ld || e.st) ? 3 + k : 3;
  endfunction

  function automatic bit tmo_of(input exp_t e, input int k);
    return (e.kind == K_OK) && (e.ld || e.st) && (k > TO);
  endfunction

  // Expected outputs for cycle t after the handshake (t=0 is the handshake cycle)
  task automatic check_cycle(input int d, input exp_t e, input int t, input int k);
    string p;
    bit    ok, to, back;
    int    wb, mend;
    p    = d ? "rv64" : "rv32";
    ok   = (e.kind == K_OK);
    to   = tmo_of(e, k);
    back = ok && !to;
    wb   = wb_of(e, k);
    mend = 2 + (to ? TO : k);
    chk({p, ".inst_ready"}, 32'(inst_ready[d]), 32'((t == 0) || (back && t > wb)));
    chk({p, ".pc_we"},   32'(pc_we[d]),   32'(back && t == wb));
    chk({p, ".reg_we"},  32'(reg_we[d]),  32'(back && t == wb && e.wr));
    chk({p, ".mem_rd"},  32'(mem_rd[d]),  32'(ok && e.ld && t >= 3 && t <= mend));
    chk({p, ".mem_wr"},  32'(mem_wr[d]),  32'(ok && e.st && t >= 3 && t <= mend));
    chk({p, ".halt"},    32'(halt[d]),    32'(e.kind == K_HALT && t >= 2));
    chk({p, ".illegal"}, 32'(illegal[d]), 32'(e.kind == K_ILL && t >= 2));
    chk({p, ".timeout"}, 32'(timeout[d]), 32'(to && t >= 3 + TO));
    if (ok && t >= 2) begin
      chk({p, ".i_type"},  32'(i_type[d]),     32'(e.ity));
      chk({p, ".a_src"},   32'(alu_a_src[d]),  32'(e.a));
      chk({p, ".b_src"},   32'(alu_b_src[d]),  32'(e.b));
      chk({p, ".alu_ctr"}, 32'(alu_ctr[d]),    32'(e.alu));
      chk({p, ".alu_word"},32'(alu_word[d]),   32'(e.word));
      chk({p, ".m2r"},     32'(mem_to_reg[d]), 32'(e.m2r));
      chk({p, ".mem_op"},  32'(mem_op[d]),     32'(e.mop));
      chk({p, ".branch"},  32'(branch[d]),     32'(e.br));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; inst_valid = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rst.inst_ready", 32'(inst_ready[d]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; inst_valid = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst.inst_ready", 32'(inst_ready[d]), 32'd1);
      chk("post_rst.strobes", 32'({pc_we[d], reg_we[d], mem_rd[d], mem_wr[d]}), 32'd0);
      chk("post_rst.sticky", 32'({halt[d], illegal[d], timeout[d]}), 32'd0);
      chk("post_rst.bundle", 32'({i_type[d], alu_a_src[d], alu_b_src[d], alu_ctr[d], alu_word[d],
                                  mem_to_reg[d], mem_op[d], branch[d]}), 32'd0);
    end
  endtask

  // One instruction: k = MEM cycle carrying mem_done, hold = extra cycles watched in HALT/ERR,
  // abort = cycle at which reset is applied instead of finishing (0 = never)
  task automatic run_inst(input logic [31:0] ins, input int k, input int hold, input int abort);
    exp_t e [2];
    int   tend, idle_t, te;
    bit   mem, need_rst;
    logic [31:0] r;
    e[0] = model(ins, 1'b0);
    e[1] = model(ins, 1'b1);
    mem  = e[1].ld || e[1].st;
    tend = 0; idle_t = 1000; need_rst = 0;
    for (int d = 0; d < 2; d++) begin
      if (e[d].kind == K_OK && !tmo_of(e[d], k)) begin
        te = wb_of(e[d], k) + 1;
        if (te < idle_t) idle_t = te;
      end else begin
        te = (tmo_of(e[d], k) ? 3 + TO : 2) + hold;
        need_rst = 1;
      end
      if (te > tend) tend = te;
    end
    if (abort > 0) tend = abort;
    @(posedge clk); #1;
    r = $urandom;
    inst_valid = 1'b1; inst = ins; mem_done = r[0];
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_cycle(d, e[d], 0, k);
    for (int t = 1; t <= tend; t++) begin
      @(posedge clk); #1;
      r = $urandom;
      inst_valid = (t < idle_t) ? r[0] : 1'b0;
      inst       = $urandom;
      mem_done   = (mem && t >= 3 && t <= 2 + k) ? (t == 2 + k) : r[1];
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_cycle(d, e[d], t, k);
    end
    inst_valid = 1'b0;
    if (need_rst || abort > 0) do_reset();
  endtask

  logic [6:0]  ops [11];
  logic [31:0] rnd, ins;
  int          sel;

  initial begin
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
    do_reset();
    run_inst(32'h0050_0093, 1, 3, 0);   // addi x1,x0,5
    run_inst(32'h0000_A103, 3, 3, 0);   // lw x2,0(x1), done on 3rd MEM cycle
    run_inst(32'h0020_A023, 9, 3, 0);   // sw, never completes
    run_inst(32'hFFFF_FFFF, 1, 20, 0);  // illegal, ERR held
    run_inst(32'h0010_0073, 1, 4, 0);   // ebreak
    run_inst(32'h0020_8463, 1, 3, 0);   // beq
    run_inst(32'h0020_81BB, 1, 3, 0);   // addw
    run_inst(32'h0000_B103, 1, 3, 0);   // ld: rv64 only
    run_inst(32'h0000_A103, 9, 3, 4);   // reset while waiting in MEM
    run_inst(32'h0000_0013, 1, 3, 0);   // addi x0: no reg_we
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 13);
      rnd = $urandom;
      if (sel < 11) begin
        ins = {rnd[31:7], ops[sel]};
        if (rnd[3:2] == 2'b00) ins[11:7] = 5'd0;
      end else if (sel == 11) ins = 32'h0010_0073;
      else if (sel == 12)     ins = rnd;
      else                    ins = {rnd[31:7], 7'h73};
      run_inst(ins, $urandom_range(1, 6), 2, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
